// File: rtl/tag_lookup_ctrl_if.sv
// CPU-side lookup handshake for tag_lookup_ctrl: request address in, hit/miss/error response out.
interface tag_lookup_ctrl_if #(
    parameter int TAG_W = 5,
    parameter int IDX_W = 3
);
    logic                   req_valid;
    logic [TAG_W+IDX_W-1:0] req_addr;
    logic                   req_ready;
    logic                   resp_valid;
    logic                   resp_hit;
    logic                   resp_err;

    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_hit, resp_err);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_hit, resp_err);
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Tag-array lookup sequencer: read, compare, refill on miss, saturating hit/miss counters.
// Optional whole-array flush is compiled in with `define TAG_FLUSH_EN.
module tag_lookup_ctrl #(
    parameter int TAG_W   = 5,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 7,
    parameter int CNT_W   = 16
) (
    input  logic                   CC_clk,
    input  logic                   rst,
    tag_lookup_ctrl_if.slave       cpu,
    output logic                   ta_read_enable,
    output logic [IDX_W-1:0]       ta_read_select,
    input  logic [TAG_W:0]         ta_out_data,
    input  logic                   ta_finish,
    output logic                   ta_write_enable,
    output logic [IDX_W-1:0]       ta_write_select,
    output logic [TAG_W:0]         ta_write_data,
    output logic                   mem_req,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    input  logic                   mem_ack,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
`ifdef TAG_FLUSH_EN
    ,
    input  logic                   flush_req,
    output logic                   flush_done
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_COMPARE, S_REFILL, S_UPDATE
`ifdef TAG_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t                 state, state_d;
    logic [TAG_W+IDX_W-1:0] addr_q;
    logic [TAG_W:0]         data_q;
    logic [TW-1:0]          tmo_cnt;
    logic                   resp_valid_q, resp_hit_q, resp_err_q;
    logic [CNT_W-1:0]       hit_cnt, miss_cnt;
    logic                   is_hit;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic                   tmo_last;
`ifdef TAG_FLUSH_EN
    logic [IDX_W-1:0]       flush_idx;
    logic                   flush_done_q;
`endif

    assign idx      = addr_q[IDX_W-1:0];
    assign tag      = addr_q[TAG_W+IDX_W-1:IDX_W];
    assign is_hit   = data_q[TAG_W] && (data_q[TAG_W-1:0] == tag);
    assign tmo_last = (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
`ifdef TAG_FLUSH_EN
                if (flush_req)
                    state_d = S_FLUSH;
                else
`endif
                if (cpu.req_valid)
                    state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (ta_finish)
                    state_d = S_COMPARE;
                else if (tmo_last)
                    state_d = S_IDLE;
            end
            S_COMPARE: state_d = is_hit ? S_IDLE : S_REFILL;
            S_REFILL:  if (mem_ack) state_d = S_UPDATE;
            S_UPDATE:  state_d = S_IDLE;
`ifdef TAG_FLUSH_EN
            S_FLUSH:   if (flush_idx == '1) state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Handshake strobes are pure state decodes, so no input reaches an output combinationally.
    always_comb begin
        cpu.req_ready   = (state == S_IDLE);
        ta_read_enable  = (state == S_LOOKUP);
        mem_req         = (state == S_REFILL);
        ta_write_enable = (state == S_UPDATE);
        ta_write_select = idx;
        ta_write_data   = '0;
        if (state == S_UPDATE)
            ta_write_data = {1'b1, tag};
`ifdef TAG_FLUSH_EN
        if (state == S_FLUSH) begin
            ta_write_enable = 1'b1;
            ta_write_select = flush_idx;
        end
`endif
    end

    assign ta_read_select = idx;
    assign mem_addr       = addr_q;
    assign cpu.resp_valid = resp_valid_q;
    assign cpu.resp_hit   = resp_hit_q;
    assign cpu.resp_err   = resp_err_q;
    assign hit_count      = hit_cnt;
    assign miss_count     = miss_cnt;
`ifdef TAG_FLUSH_EN
    assign flush_done     = flush_done_q;
`endif

    always_ff @(posedge CC_clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            tmo_cnt      <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
`ifdef TAG_FLUSH_EN
            flush_idx    <= '0;
            flush_done_q <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b0;
`ifdef TAG_FLUSH_EN
            flush_done_q <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
`ifdef TAG_FLUSH_EN
                    if (flush_req)
                        flush_idx <= '0;
                    else
`endif
                    if (cpu.req_valid) begin
                        addr_q  <= cpu.req_addr;
                        tmo_cnt <= '0;
                    end
                end
                S_LOOKUP: begin
                    if (ta_finish)
                        data_q <= ta_out_data;
                    else if (tmo_last) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                S_COMPARE: begin
                    if (is_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                    end else if (miss_cnt != '1)
                        miss_cnt <= miss_cnt + 1'b1;
                end
                S_UPDATE: resp_valid_q <= 1'b1;
`ifdef TAG_FLUSH_EN
                S_FLUSH: begin
                    flush_idx <= flush_idx + 1'b1;
                    if (flush_idx == '1) flush_done_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
